al_seq_multiplier: RTL and testbench
====================================

// Module: al_seq_multiplier
// PURPOSE
//  Parametrised sequential shift-add multiplier: N x N -> 2N product, K multiplier bits per cycle.
//  Per-transaction signed/unsigned mode; valid/ready handshake on both input and output sides.
//  Shared arithmetic unit for synthesizer DSP paths (envelope x amplitude, gain scaling) at mclk.
// PARAMETERS
//  N     16    operand width; N >= 2
//  K     1     multiplier bits retired per cycle; power of two dividing N, else elaboration $error
//  FRAC  N-1   fixed-point fraction bits for optional rounded output; 1 <= FRAC <= 2N-2
// PORTS
//  mclk       in   1    master clock, all state on rising edge
//  rst_n      in   1    asynchronous active-low reset
//  clr        in   1    synchronous abort: discard any transaction, return to IDLE
//  in_valid   in   1    operands valid
//  in_ready   out  1    block can accept operands (IDLE only)
//  in_a       in   N    multiplicand
//  in_b       in   N    multiplier
//  in_signed  in   1    1 = two's-complement operands, 0 = unsigned; sampled with operands
//  out_valid  out  1    result valid, held until accepted
//  out_ready  in   1    downstream accepts result
//  result     out  2N   product, held stable while out_valid=1
//  busy       out  1    state != IDLE
//  sync       out  1    one-cycle pulse on the edge result is written
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, out_valid=0, result=0, busy=0, sync=0, in_ready=1, accum/counters 0.
//  FSM IDLE -> RUN -> DONE -> IDLE; in_ready = (state==IDLE), combinational from state register.
//  IDLE: on in_valid & in_ready edge latch |in_a|, |in_b|, neg = in_signed & (a[N-1]^b[N-1]); clear accum; -> RUN.
//   Signed magnitude: |-2^(N-1)| = 2^(N-1), held in N-bit unsigned; no overflow possible.
//  RUN: counter 0..N/K-1; each edge accum += |a| * b_chunk(K bits, LSB first) << (K*count); b shifts right K.
//   Last RUN edge: result <= neg ? -(sum) : sum (2N-bit wrap), out_valid<=1, sync<=1, -> DONE.
//  Latency: out_valid high exactly N/K edges after the accept edge (N=16,K=1: 16; K=4: 4).
//  DONE: result/out_valid stable; in_valid ignored (in_ready=0); on out_valid & out_ready edge: out_valid<=0 -> IDLE.
//   Next accept therefore no earlier than the edge after output handshake; result keeps last value after.
//  clr=1 (any state): next edge -> IDLE, out_valid<=0, sync<=0, accum cleared; result retains last value.
//   clr with in_valid in IDLE: clr wins, no accept. clr with output handshake: transaction treated as consumed.
//  rst_n low mid-RUN/DONE: immediate reset values; partial product discarded; no sync pulse.
//  Unsigned mode: full 2N-bit unsigned product. Signed mode: 2N-bit two's-complement product.
//  Internal counter width $clog2(N/K+1); accum 2N bits; no combinational in->out paths except in_ready.
// CONFIGURATION
//  Macro AL_MULT_ROUND_EN:
//   defined: adds port result_rnd out N = product rounded half-up at bit FRAC-1, shifted right FRAC,
//    saturated to N-bit signed range (signed mode) or [0, 2^N-1] (unsigned); registered with result, reset 0.
//   undefined: port and rounding/saturation logic absent; all other behaviour identical.
// TESTING
//  1 N=16,K=1 unsigned 0xFFFF x 0xFFFF -> result 0xFFFE0001, out_valid 16 edges after accept, sync one cycle.
//  2 signed 0x8000 x 0x8000 -> 0x40000000; signed 0xFFFF x 0x0003 -> 0xFFFFFFFD; unsigned 0xFFFF x 3 -> 0x0002FFFD.
//  3 N=16,K=4 unsigned 0x1234 x 0x5678 -> 0x06260060, latency 4 edges; back-to-back with out_ready=1 throughout.
//  4 out_ready=0 for 10 cycles in DONE, in_valid toggling -> result stable, in_ready=0, no accept; then handshake -> IDLE.
//  5 clr at RUN count 5 -> IDLE next edge, out_valid never rises; rst_n pulsed low mid-RUN -> all reset values at once.
//  6 AL_MULT_ROUND_EN, FRAC=15 signed: 0x4000 x 0x4000 -> result_rnd 0x2000; 0x8000 x 0x8000 -> saturates 0x7FFF.

Source files
------------

// File: rtl/al_seq_multiplier.sv
// Sequential shift-add N x N -> 2N multiplier retiring K multiplier bits per cycle, signed/unsigned per transaction.
// Optional AL_MULT_ROUND_EN adds a rounded, saturated N-bit fixed-point output (result_rnd).
module al_seq_multiplier #(
    parameter int unsigned N    = 16,
    parameter int unsigned K    = 1,
    parameter int unsigned FRAC = N - 1
) (
    input  logic             mclk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   result,
`ifdef AL_MULT_ROUND_EN
    output logic [N-1:0]     result_rnd,
`endif
    output logic             busy,
    output logic             sync
);

    localparam int unsigned PW    = 2 * N;
    localparam int unsigned STEPS = (K == 0) ? 1 : N / K;
    localparam int unsigned CW    = $clog2(STEPS + 1);

    if (N < 2) begin : g_bad_n
        $error("al_seq_multiplier: N must be >= 2");
    end
    if ((K == 0) || ((N % K) != 0) || ((K & (K - 1)) != 0)) begin : g_bad_k
        $error("al_seq_multiplier: K must be a power of two dividing N");
    end
    if ((FRAC < 1) || (FRAC > 2 * N - 2)) begin : g_bad_frac
        $error("al_seq_multiplier: FRAC must lie in 1..2N-2");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    a_mag_q, a_mag_d;
    logic [N-1:0]    b_q, b_d;
    logic            neg_q, neg_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   accum_q, accum_d;
    logic [PW-1:0]   result_q, result_d;
    logic            out_valid_q, out_valid_d;
    logic            sync_q, sync_d;
    logic            busy_q, busy_d;
    logic [PW-1:0]   step_sum;
`ifdef AL_MULT_ROUND_EN
    logic            sgn_q, sgn_d;
    logic [N-1:0]    rnd_q, rnd_d;

    // Round half-up at bit FRAC-1, drop FRAC bits, clamp to the N-bit range of the mode.
    function automatic logic [N-1:0] round_sat(input logic [PW-1:0] p, input logic s);
        logic [PW:0] ext;
        logic [PW:0] sum;
        logic [PW:0] shf;
        ext = s ? {p[PW-1], p} : {1'b0, p};
        sum = ext + ((PW + 1)'(1) << (FRAC - 1));
        shf = s ? (PW + 1)'($signed(sum) >>> FRAC) : (sum >> FRAC);
        if (s) begin
            if ((&shf[PW:N-1]) || (~|shf[PW:N-1])) begin
                round_sat = shf[N-1:0];
            end else begin
                round_sat = shf[PW] ? {1'b1, {(N - 1){1'b0}}} : {1'b0, {(N - 1){1'b1}}};
            end
        end else begin
            round_sat = (|shf[PW:N]) ? {N{1'b1}} : shf[N-1:0];
        end
    endfunction
`endif

    // Next-state, datapath and output logic.
    always_comb begin
        state_d     = state_q;
        a_mag_d     = a_mag_q;
        b_d         = b_q;
        neg_d       = neg_q;
        cnt_d       = cnt_q;
        accum_d     = accum_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        sync_d      = 1'b0;
`ifdef AL_MULT_ROUND_EN
        sgn_d       = sgn_q;
        rnd_d       = rnd_q;
`endif
        step_sum = accum_q + ((PW'(a_mag_q) * PW'(b_q[K-1:0])) << (K * 32'(cnt_q)));

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_mag_d = (in_signed & in_a[N-1]) ? (~in_a + N'(1)) : in_a;
                    b_d     = (in_signed & in_b[N-1]) ? (~in_b + N'(1)) : in_b;
                    neg_d   = in_signed & (in_a[N-1] ^ in_b[N-1]);
                    accum_d = '0;
                    cnt_d   = '0;
`ifdef AL_MULT_ROUND_EN
                    sgn_d   = in_signed;
`endif
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                accum_d = step_sum;
                b_d     = b_q >> K;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(STEPS - 1)) begin
                    result_d    = neg_q ? (~step_sum + PW'(1)) : step_sum;
                    out_valid_d = 1'b1;
                    sync_d      = 1'b1;
                    cnt_d       = '0;
`ifdef AL_MULT_ROUND_EN
                    rnd_d       = round_sat(result_d, sgn_q);
`endif
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over everything, including a pending accept or output handshake.
        if (clr) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            sync_d      = 1'b0;
            accum_d     = '0;
            cnt_d       = '0;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_mag_q     <= '0;
            b_q         <= '0;
            neg_q       <= 1'b0;
            cnt_q       <= '0;
            accum_q     <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            sync_q      <= 1'b0;
            busy_q      <= 1'b0;
`ifdef AL_MULT_ROUND_EN
            sgn_q       <= 1'b0;
            rnd_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            a_mag_q     <= a_mag_d;
            b_q         <= b_d;
            neg_q       <= neg_d;
            cnt_q       <= cnt_d;
            accum_q     <= accum_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            sync_q      <= sync_d;
            busy_q      <= busy_d;
`ifdef AL_MULT_ROUND_EN
            sgn_q       <= sgn_d;
            rnd_q       <= rnd_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign busy      = busy_q;
    assign sync      = sync_q;
`ifdef AL_MULT_ROUND_EN
    assign result_rnd = rnd_q;
`endif

endmodule

// File: tb/tb_al_seq_multiplier.sv
// Bench for al_seq_multiplier: K=1 and K=4 instances checked every cycle against a transaction-level model,
// plus directed vectors with hand-computed results.
module tb_al_seq_multiplier;

    localparam int unsigned FRAC = 15;

    logic        mclk = 1'b0;
    logic        rst_n;
    logic        clr       [2];
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [15:0] in_a      [2];
    logic [15:0] in_b      [2];
    logic        in_signed [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [31:0] result    [2];
    logic        busy      [2];
    logic        sync      [2];
`ifdef AL_MULT_ROUND_EN
    logic [15:0] result_rnd [2];
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 mclk = ~mclk;

    al_seq_multiplier #(.N(16), .K(1)) u_k1 (
        .mclk(mclk), .rst_n(rst_n), .clr(clr[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_a(in_a[0]), .in_b(in_b[0]), .in_signed(in_signed[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .result(result[0]),
`ifdef AL_MULT_ROUND_EN
        .result_rnd(result_rnd[0]),
`endif
        .busy(busy[0]), .sync(sync[0])
    );

    al_seq_multiplier #(.N(16), .K(4)) u_k4 (
        .mclk(mclk), .rst_n(rst_n), .clr(clr[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_a(in_a[1]), .in_b(in_b[1]), .in_signed(in_signed[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .result(result[1]),
`ifdef AL_MULT_ROUND_EN
        .result_rnd(result_rnd[1]),
`endif
        .busy(busy[1]), .sync(sync[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: plain integer product of the operands in the requested mode.
    function automatic logic [31:0] mul(input logic [15:0] a, input logic [15:0] b, input logic s);
        longint x;
        longint y;
        x = s ? longint'($signed(a)) : longint'(a);
        y = s ? longint'($signed(b)) : longint'(b);
        return 32'(x * y);
    endfunction

`ifdef AL_MULT_ROUND_EN
    function automatic logic [15:0] rnd(input logic [31:0] p, input logic s);
        longint v;
        longint r;
        v = s ? longint'($signed(p)) : longint'(p);
        r = (v + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
        if (s) begin
            if (r > 32767)  return 16'h7FFF;
            if (r < -32768) return 16'h8000;
        end else if (r > 65535) begin
            return 16'hFFFF;
        end
        return 16'(r);
    endfunction
`endif

    function automatic int steps(input int i);
        return (i == 0) ? 16 : 4;
    endfunction

    // Transaction model: 0 idle, 1 computing (remaining edges), 2 result waiting for handshake.
    int          m_state [2];
    int          m_cnt   [2];
    logic        m_ov    [2];
    logic        m_sync  [2];
    logic [31:0] m_res   [2];
    logic [31:0] m_pend  [2];
`ifdef AL_MULT_ROUND_EN
    logic        m_psgn  [2];
    logic [15:0] m_rnd   [2];
`endif

    always @(posedge mclk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_state[i] <= 0;
                m_cnt[i]   <= 0;
                m_ov[i]    <= 1'b0;
                m_sync[i]  <= 1'b0;
                m_res[i]   <= '0;
                m_pend[i]  <= '0;
`ifdef AL_MULT_ROUND_EN
                m_psgn[i]  <= 1'b0;
                m_rnd[i]   <= '0;
`endif
            end else begin
                m_sync[i] <= 1'b0;
                if (clr[i]) begin
                    m_state[i] <= 0;
                    m_ov[i]    <= 1'b0;
                end else if (m_state[i] == 0) begin
                    if (in_valid[i]) begin
                        m_pend[i]  <= mul(in_a[i], in_b[i], in_signed[i]);
`ifdef AL_MULT_ROUND_EN
                        m_psgn[i]  <= in_signed[i];
`endif
                        m_cnt[i]   <= steps(i);
                        m_state[i] <= 1;
                    end
                end else if (m_state[i] == 1) begin
                    if (m_cnt[i] == 1) begin
                        m_res[i]   <= m_pend[i];
`ifdef AL_MULT_ROUND_EN
                        m_rnd[i]   <= rnd(m_pend[i], m_psgn[i]);
`endif
                        m_ov[i]    <= 1'b1;
                        m_sync[i]  <= 1'b1;
                        m_state[i] <= 2;
                    end else begin
                        m_cnt[i] <= m_cnt[i] - 1;
                    end
                end else if (out_ready[i]) begin
                    m_ov[i]    <= 1'b0;
                    m_state[i] <= 0;
                end
            end
        end
    end

    // Cycle compare against the model, away from the active edge.
    always @(negedge mclk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("cyc_in_ready[%0d]", i), 64'(in_ready[i]), 64'(m_state[i] == 0));
            chk($sformatf("cyc_busy[%0d]", i), 64'(busy[i]), 64'(m_state[i] != 0));
            chk($sformatf("cyc_out_valid[%0d]", i), 64'(out_valid[i]), 64'(m_ov[i]));
            chk($sformatf("cyc_sync[%0d]", i), 64'(sync[i]), 64'(m_sync[i]));
            chk($sformatf("cyc_result[%0d]", i), 64'(result[i]), 64'(m_res[i]));
`ifdef AL_MULT_ROUND_EN
            chk($sformatf("cyc_result_rnd[%0d]", i), 64'(result_rnd[i]), 64'(m_rnd[i]));
`endif
        end
    end

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    // Present operands, wait for accept, then count edges until out_valid and check the literal result.
    task automatic op(input int i, input logic [15:0] a, input logic [15:0] b, input logic s,
                      input logic keep, input logic [31:0] exp, input int lat);
        int   n;
        logic acc;
        in_a[i]      = a;
        in_b[i]      = b;
        in_signed[i] = s;
        in_valid[i]  = 1'b1;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 200) begin
            acc = in_ready[i];
            tick();
            n++;
        end
        chk("accept", 64'(acc), 64'(1));
        if (!keep) in_valid[i] = 1'b0;
        n = 0;
        while (!out_valid[i] && n < 200) begin
            tick();
            n++;
        end
        chk("latency", 64'(n), 64'(lat));
        chk("result", 64'(result[i]), 64'(exp));
        chk("sync_pulse", 64'(sync[i]), 64'(1));
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            clr[i] = 1'b0; in_valid[i] = 1'b0; in_a[i] = '0; in_b[i] = '0;
            in_signed[i] = 1'b0; out_ready[i] = 1'b0;
        end
        tick();
        chk("rst_result", 64'(result[0]), 64'(0));
        chk("rst_out_valid", 64'(out_valid[0]), 64'(0));
        chk("rst_busy", 64'(busy[0]), 64'(0));
        chk("rst_in_ready", 64'(in_ready[0]), 64'(1));
        chk("rst_sync", 64'(sync[1]), 64'(0));
        tick();
        rst_n = 1'b1;
        tick();

        // Unsigned full-scale, output held while out_ready low.
        op(0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 32'hFFFE0001, 16);
        tick();
        chk("sync_one_cycle", 64'(sync[0]), 64'(0));
        chk("valid_held", 64'(out_valid[0]), 64'(1));
        out_ready[0] = 1'b1;
        tick();
        chk("idle_after_hs", 64'(in_ready[0]), 64'(1));

        // Signed corners and the unsigned counterpart.
        op(0, 16'h8000, 16'h8000, 1'b1, 1'b0, 32'h40000000, 16);
        op(0, 16'hFFFF, 16'h0003, 1'b1, 1'b0, 32'hFFFFFFFD, 16);
        op(0, 16'hFFFF, 16'h0003, 1'b0, 1'b0, 32'h0002FFFD, 16);

        // K=4 back-to-back with in_valid held and out_ready high throughout.
        out_ready[1] = 1'b1;
        op(1, 16'h1234, 16'h5678, 1'b0, 1'b1, 32'h06260060, 4);
        op(1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 32'hFFFE0001, 4);
        op(1, 16'h8000, 16'h7FFF, 1'b1, 1'b0, 32'hC0008000, 4);

        // Stall in DONE with in_valid toggling.
        tick();
        out_ready[0] = 1'b0;
        op(0, 16'h0102, 16'h0304, 1'b0, 1'b0, 32'h00030A08, 16);
        for (int j = 0; j < 10; j++) begin
            in_valid[0] = 1'(j % 2);
            in_a[0]     = 16'($urandom);
            in_b[0]     = 16'($urandom);
            tick();
            chk("stall_result", 64'(result[0]), 64'(32'h00030A08));
            chk("stall_in_ready", 64'(in_ready[0]), 64'(0));
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        tick();
        chk("stall_release_valid", 64'(out_valid[0]), 64'(0));
        chk("stall_release_ready", 64'(in_ready[0]), 64'(1));
        chk("stall_release_result", 64'(result[0]), 64'(32'h00030A08));

        // Abort at RUN count 5; then clr racing an accept in IDLE.
        in_a[0] = 16'd3; in_b[0] = 16'd5; in_signed[0] = 1'b0; in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        repeat (5) tick();
        clr[0] = 1'b1;
        tick();
        chk("clr_busy", 64'(busy[0]), 64'(0));
        chk("clr_in_ready", 64'(in_ready[0]), 64'(1));
        chk("clr_result_kept", 64'(result[0]), 64'(32'h00030A08));
        in_valid[0] = 1'b1;
        tick();
        chk("clr_beats_accept", 64'(busy[0]), 64'(0));
        clr[0] = 1'b0;
        in_valid[0] = 1'b0;
        for (int j = 0; j < 20; j++) begin
            tick();
            if (j % 5 == 0) chk("clr_no_valid", 64'(out_valid[0]), 64'(0));
        end

        // Asynchronous reset mid-RUN.
        in_a[0] = 16'd7; in_b[0] = 16'd9; in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("arst_result", 64'(result[0]), 64'(0));
        chk("arst_busy", 64'(busy[0]), 64'(0));
        chk("arst_in_ready", 64'(in_ready[0]), 64'(1));
        chk("arst_out_valid", 64'(out_valid[0]), 64'(0));
        tick();
        rst_n = 1'b1;
        tick();

`ifdef AL_MULT_ROUND_EN
        out_ready[0] = 1'b1;
        op(0, 16'h4000, 16'h4000, 1'b1, 1'b0, 32'h10000000, 16);
        chk("rnd_half", 64'(result_rnd[0]), 64'(16'h2000));
        op(0, 16'h8000, 16'h8000, 1'b1, 1'b0, 32'h40000000, 16);
        chk("rnd_sat_pos", 64'(result_rnd[0]), 64'(16'h7FFF));
        op(0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 32'hFFFE0001, 16);
        chk("rnd_sat_uns", 64'(result_rnd[0]), 64'(16'hFFFF));
`endif

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
